// File: rtl/datamover_h.sv
// datamover_h: AXI4-Lite register bank that issues one 72-bit AXI DataMover command per START rising edge.
// Optional feature macro DATAMOVERH_BUSY_STATUS_EN exposes BUSY (= po_valid) on REG3[1].
module datamover_h #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  // DataMover command stream
  output logic [71:0]                     po_command,
  output logic                            po_valid,
  input  logic                            pi_ready,
  // AXI4-Lite write address
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  // AXI4-Lite write data
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  // AXI4-Lite write response
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  // AXI4-Lite read address
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  // AXI4-Lite read data
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic {
    CMD_IDLE,
    CMD_ISSUE
  } cmd_state_e;

  logic [DW-1:0] reg0_q, reg0_d;
  logic [DW-1:0] reg1_q, reg1_d;
  logic [DW-1:0] reg2_q, reg2_d;
  logic          bvalid_q, bvalid_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          start_prev_q, start_prev_d;
  logic          done_q, done_d;
  cmd_state_e    cmd_state_q, cmd_state_d;
  logic [71:0]   cmd_q, cmd_d;

  logic          wr_hs;
  logic          rd_hs;
  logic          start_rise;
  logic          busy_bit;
  logic [DW-1:0] status_word;
  logic [DW-1:0] rd_mux;

  // Protection bits and the upper address bits carry no meaning for this bank.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2],
                           S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]};

  function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_v,
                                               input logic [DW-1:0] new_v,
                                               input logic [SW-1:0] strb);
    logic [DW-1:0] res;
    res = old_v;
    for (int b = 0; b < SW; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

`ifdef DATAMOVERH_BUSY_STATUS_EN
  assign busy_bit = po_valid;
`else
  assign busy_bit = 1'b0;
`endif

  assign status_word = {{(DW-2){1'b0}}, busy_bit, done_q};

  // Address and data are accepted together, and only when no response is pending.
  assign wr_hs = S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q;
  assign rd_hs = S_AXI_ARVALID && !rvalid_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    reg0_d   = reg0_q;
    reg1_d   = reg1_q;
    reg2_d   = reg2_q;
    bvalid_d = bvalid_q;
    if (wr_hs) begin
      unique case (S_AXI_AWADDR[1:0])
        2'd0:    reg0_d = apply_strb(reg0_q, S_AXI_WDATA, S_AXI_WSTRB);
        2'd1:    reg1_d = apply_strb(reg1_q, S_AXI_WDATA, S_AXI_WSTRB);
        2'd2:    reg2_d = apply_strb(reg2_q, S_AXI_WDATA, S_AXI_WSTRB);
        default: ;
      endcase
      bvalid_d = 1'b1;
    end else if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (S_AXI_ARADDR[1:0])
      2'd0:    rd_mux = reg0_q;
      2'd1:    rd_mux = reg1_q;
      2'd2:    rd_mux = reg2_q;
      default: rd_mux = status_word;
    endcase
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (rd_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  // START is level-stored; the previous value is tracked every cycle so an
  // edge seen while a command is outstanding is consumed rather than queued.
  assign start_rise   = reg2_q[10] && !start_prev_q;
  assign start_prev_d = reg2_q[10];

  always_comb begin
    cmd_state_d = cmd_state_q;
    cmd_d       = cmd_q;
    done_d      = done_q;
    unique case (cmd_state_q)
      CMD_IDLE: begin
        if (start_rise) begin
          cmd_state_d = CMD_ISSUE;
          cmd_d       = {reg1_q[7:0], reg0_q, 1'b0, 1'b1, 6'b0, 1'b1, 13'b0, reg2_q[9:0]};
          done_d      = 1'b0;
        end
      end
      CMD_ISSUE: begin
        if (pi_ready) begin
          cmd_state_d = CMD_IDLE;
          done_d      = 1'b1;
        end
      end
      default: cmd_state_d = CMD_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      reg0_q       <= '0;
      reg1_q       <= '0;
      reg2_q       <= '0;
      bvalid_q     <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      start_prev_q <= 1'b0;
      done_q       <= 1'b0;
      cmd_state_q  <= CMD_IDLE;
      cmd_q        <= '0;
    end else begin
      reg0_q       <= reg0_d;
      reg1_q       <= reg1_d;
      reg2_q       <= reg2_d;
      bvalid_q     <= bvalid_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      start_prev_q <= start_prev_d;
      done_q       <= done_d;
      cmd_state_q  <= cmd_state_d;
      cmd_q        <= cmd_d;
    end
  end

  assign po_valid      = (cmd_state_q == CMD_ISSUE);
  assign po_command    = cmd_q;
  assign S_AXI_AWREADY = wr_hs;
  assign S_AXI_WREADY  = wr_hs;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = rd_hs;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;

endmodule

// File: tb/tb_datamover_h.sv
// tb_datamover_h: scoreboard bench for datamover_h; expected read data and commands are queued
// when stimulus is driven and popped when the DUT produces them.
module tb_datamover_h;

  localparam int BUDGET = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [71:0] po_command;
  logic        po_valid;
  logic        pi_ready = 1'b0;
  logic [4:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [4:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] rd_exp_q[$];
  logic [71:0] cmd_exp_q[$];

`ifdef DATAMOVERH_BUSY_STATUS_EN
  localparam logic [31:0] STATUS_BUSY = 32'h2;
`else
  localparam logic [31:0] STATUS_BUSY = 32'h0;
`endif

  always #5 clk = ~clk;

  datamover_h dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .po_command    (po_command),
    .po_valid      (po_valid),
    .pi_ready      (pi_ready),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready)
  );

  task automatic timeout(input string what);
    vectors++;
    miscompares++;
    $display("FAIL timeout_%s: no DUT response within %0d cycles", what, BUDGET);
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n;
    resp   = 2'bxx;
    awaddr = a;
    wdata  = d;
    wstrb  = s;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(awready && wready) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) timeout("awready");
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bvalid && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) timeout("bvalid");
    resp = bresp;
    @(posedge clk);
    #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    araddr  = a;
    arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) timeout("arready");
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    rready  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rvalid && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) timeout("rvalid");
    d    = rdata;
    resp = rresp;
    @(posedge clk);
    #1;
    rready = 1'b0;
  endtask

  task automatic wait_cmd(output bit seen);
    int n;
    n = 0;
    @(negedge clk);
    while (!po_valid && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    seen = po_valid;
    if (!seen) timeout("po_valid");
  endtask

  task automatic test_reset;
    logic [31:0] d, exp;
    logic [1:0]  r;
    #3;
    vectors++;
    if ({po_valid, po_command, awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: po_valid=%b po_command=%h aw=%b w=%b b=%b r=%b rdata=%h, required all 0",
               po_valid, po_command, awready, wready, bvalid, rvalid, rdata);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd_exp_q.push_back(32'h0);
      axi_read(5'(i), d, r);
      exp = rd_exp_q.pop_front();
      vectors++;
      if (d !== exp || r !== 2'b00) begin
        miscompares++;
        $display("FAIL reset_read_reg%0d: got %h resp %b, expected %h resp 00", i, d, r, exp);
      end
    end
  endtask

  task automatic test_launch;
    logic [1:0] r;
    axi_write(5'd0, 32'hFFFF_FFFF, 4'hF, r);
    vectors++;
    if (r !== 2'b00) begin
      miscompares++;
      $display("FAIL launch_bresp: got %b expected 00", r);
    end
    axi_write(5'd1, 32'hFFFF_FFFF, 4'hF, r);
    axi_write(5'd2, 32'h0000_03FF, 4'hF, r);
    repeat (3) @(negedge clk);
    vectors++;
    if (po_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL launch_no_start: po_valid=%b expected 0", po_valid);
    end
    @(posedge clk);
    #1;
    axi_write(5'd2, 32'h0000_07FF, 4'hF, r);
    cmd_exp_q.push_back(72'hFF_FFFFFFFF_408003FF);
    vectors++;
    if (po_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL launch_latency: po_valid=%b one edge after START write, expected 1", po_valid);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (po_valid !== 1'b1 || po_command !== cmd_exp_q[0]) begin
        miscompares++;
        $display("FAIL launch_hold%0d: valid=%b cmd=%h expected valid=1 cmd=%h",
                 i, po_valid, po_command, cmd_exp_q[0]);
      end
    end
  endtask

  task automatic test_done;
    logic [31:0] d, exp;
    logic [71:0] cexp;
    logic [1:0]  r;
    @(posedge clk);
    #1;
    pi_ready = 1'b1;
    @(negedge clk);
    cexp = cmd_exp_q.pop_front();
    vectors++;
    if (po_valid !== 1'b1 || po_command !== cexp) begin
      miscompares++;
      $display("FAIL done_cmd: valid=%b cmd=%h expected valid=1 cmd=%h", po_valid, po_command, cexp);
    end
    @(posedge clk);
    #1;
    pi_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (po_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL done_drop: po_valid=%b after accept, expected 0", po_valid);
    end
    @(posedge clk);
    #1;
    rd_exp_q.push_back(32'h1);
    axi_read(5'd3, d, r);
    exp = rd_exp_q.pop_front();
    vectors++;
    if (d !== exp) begin
      miscompares++;
      $display("FAIL done_status: REG3=%h expected %h", d, exp);
    end
  endtask

  task automatic test_relaunch;
    logic [31:0] d, exp;
    logic [1:0]  r;
    bit          seen;
    axi_write(5'd0, 32'hAAAA_AAAA, 4'hF, r);
    axi_write(5'd1, 32'hAAAA_AAAA, 4'hF, r);
    axi_write(5'd2, 32'h0000_03AA, 4'hF, r);
    axi_write(5'd2, 32'h0000_07AA, 4'hF, r);
    cmd_exp_q.push_back(72'hAA_AAAAAAAA_408003AA);
    wait_cmd(seen);
    vectors++;
    if (po_command !== cmd_exp_q[0]) begin
      miscompares++;
      $display("FAIL relaunch_cmd: got %h expected %h", po_command, cmd_exp_q[0]);
    end
    @(posedge clk);
    #1;
    rd_exp_q.push_back(STATUS_BUSY);
    axi_read(5'd3, d, r);
    exp = rd_exp_q.pop_front();
    vectors++;
    if (d !== exp) begin
      miscompares++;
      $display("FAIL relaunch_status: REG3=%h expected %h (DONE cleared)", d, exp);
    end
  endtask

  task automatic test_hold;
    logic [31:0] d, exp;
    logic [71:0] cexp;
    logic [1:0]  r;
    bit          extra;
    axi_write(5'd0, 32'h1234_5678, 4'hF, r);
    vectors++;
    if (po_valid !== 1'b1 || po_command !== cmd_exp_q[0]) begin
      miscompares++;
      $display("FAIL hold_reg0_write: valid=%b cmd=%h expected valid=1 cmd=%h",
               po_valid, po_command, cmd_exp_q[0]);
    end
    axi_write(5'd2, 32'h0000_03FF, 4'hF, r);
    axi_write(5'd2, 32'h0000_07FF, 4'hF, r);
    pi_ready = 1'b1;
    @(negedge clk);
    cexp = cmd_exp_q.pop_front();
    vectors++;
    if (po_valid !== 1'b1 || po_command !== cexp) begin
      miscompares++;
      $display("FAIL hold_cmd: valid=%b cmd=%h expected valid=1 cmd=%h", po_valid, po_command, cexp);
    end
    @(posedge clk);
    #1;
    pi_ready = 1'b0;
    extra = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (po_valid) extra = 1'b1;
    end
    vectors++;
    if (extra !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_no_queue: po_valid seen=%b after busy START edge, expected 0", extra);
    end
    @(posedge clk);
    #1;
    rd_exp_q.push_back(32'h1234_5678);
    axi_read(5'd0, d, r);
    exp = rd_exp_q.pop_front();
    vectors++;
    if (d !== exp) begin
      miscompares++;
      $display("FAIL hold_reg0_read: got %h expected %h", d, exp);
    end
  endtask

  task automatic test_wstrb;
    logic [31:0] d, exp;
    logic [1:0]  r;
    axi_write(5'd0, 32'hFFFF_FFFF, 4'hF, r);
    axi_write(5'd0, 32'h0000_00EE, 4'b0001, r);
    axi_write(5'd1, 32'h5A00_0000, 4'b1000, r);
    axi_write(5'd3, 32'hFFFF_FFFF, 4'hF, r);
    rd_exp_q.push_back(32'hFFFF_FFEE);
    rd_exp_q.push_back(32'h5AAA_AAAA);
    rd_exp_q.push_back(32'h0000_0001);
    rd_exp_q.push_back(32'hFFFF_FFEE);
    axi_read(5'd0, d, r);
    exp = rd_exp_q.pop_front();
    vectors++;
    if (d !== exp) begin
      miscompares++;
      $display("FAIL wstrb_reg0: got %h expected %h", d, exp);
    end
    axi_read(5'h1D, d, r);
    exp = rd_exp_q.pop_front();
    vectors++;
    if (d !== exp) begin
      miscompares++;
      $display("FAIL wstrb_reg1_alias: got %h expected %h", d, exp);
    end
    axi_read(5'd3, d, r);
    exp = rd_exp_q.pop_front();
    vectors++;
    if (d !== exp) begin
      miscompares++;
      $display("FAIL ro_reg3: got %h expected %h", d, exp);
    end
    axi_read(5'h1C, d, r);
    exp = rd_exp_q.pop_front();
    vectors++;
    if (d !== exp) begin
      miscompares++;
      $display("FAIL alias_reg0: got %h expected %h", d, exp);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d, exp;
    logic [71:0] cexp;
    logic [1:0]  r;
    bit          seen, extra;
    int          n;
    axi_write(5'd2, 32'h0000_03FF, 4'hF, r);
    axi_write(5'd2, 32'h0000_07FF, 4'hF, r);
    cmd_exp_q.push_back(72'hAA_FFFFFFEE_408003FF);
    wait_cmd(seen);
    @(posedge clk);
    #1;
    axi_write(5'd2, 32'h0000_03FF, 4'hF, r);
    // START rises in the same cycle that the DataMover accepts the pending command.
    awaddr  = 5'd2;
    wdata   = 32'h0000_07FF;
    wstrb   = 4'hF;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!awready && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) timeout("awready_sim");
    @(posedge clk);
    #1;
    awvalid  = 1'b0;
    wvalid   = 1'b0;
    bready   = 1'b1;
    pi_ready = 1'b1;
    @(negedge clk);
    cexp = cmd_exp_q.pop_front();
    vectors++;
    if (po_valid !== 1'b1 || po_command !== cexp) begin
      miscompares++;
      $display("FAIL sim_cmd: valid=%b cmd=%h expected valid=1 cmd=%h", po_valid, po_command, cexp);
    end
    @(posedge clk);
    #1;
    pi_ready = 1'b0;
    bready   = 1'b0;
    extra = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (po_valid) extra = 1'b1;
    end
    vectors++;
    if (extra !== 1'b0) begin
      miscompares++;
      $display("FAIL sim_start_ignored: po_valid seen=%b, expected 0", extra);
    end
    @(posedge clk);
    #1;
    rd_exp_q.push_back(32'h1);
    axi_read(5'd3, d, r);
    exp = rd_exp_q.pop_front();
    vectors++;
    if (d !== exp) begin
      miscompares++;
      $display("FAIL sim_status: REG3=%h expected %h", d, exp);
    end
    // Ready already high: the command must be offered for exactly one cycle.
    pi_ready = 1'b1;
    axi_write(5'd2, 32'h0000_03FF, 4'hF, r);
    axi_write(5'd2, 32'h0000_07FF, 4'hF, r);
    cmd_exp_q.push_back(72'hAA_FFFFFFEE_408003FF);
    wait_cmd(seen);
    cexp = cmd_exp_q.pop_front();
    vectors++;
    if (po_command !== cexp) begin
      miscompares++;
      $display("FAIL b2b_cmd: got %h expected %h", po_command, cexp);
    end
    @(negedge clk);
    vectors++;
    if (po_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_one_cycle: po_valid=%b expected 0", po_valid);
    end
    @(posedge clk);
    #1;
    pi_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [31:0] d, exp;
    logic [1:0]  r;
    bit          seen;
    axi_write(5'd2, 32'h0000_03FF, 4'hF, r);
    axi_write(5'd2, 32'h0000_07FF, 4'hF, r);
    cmd_exp_q.push_back(72'hAA_FFFFFFEE_408003FF);
    wait_cmd(seen);
    #2;
    rst_n = 1'b0;
    #1;
    cmd_exp_q.delete();
    vectors++;
    if (po_valid !== 1'b0 || po_command !== 72'h0) begin
      miscompares++;
      $display("FAIL reset_mid: valid=%b cmd=%h expected valid=0 cmd=0", po_valid, po_command);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd_exp_q.push_back(32'h0);
    rd_exp_q.push_back(32'h0);
    axi_read(5'd2, d, r);
    exp = rd_exp_q.pop_front();
    vectors++;
    if (d !== exp) begin
      miscompares++;
      $display("FAIL reset_mid_reg2: got %h expected %h", d, exp);
    end
    axi_read(5'd3, d, r);
    exp = rd_exp_q.pop_front();
    vectors++;
    if (d !== exp) begin
      miscompares++;
      $display("FAIL reset_mid_reg3: got %h expected %h", d, exp);
    end
  endtask

  initial begin
    test_reset();
    test_launch();
    test_done();
    test_relaunch();
    test_hold();
    test_wstrb();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
